// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - shared constants, FSM states and butterfly address helper for the NTT address generator
package ntt_pkg;

    localparam int N      = 256;
    localparam int LAYERS = 7;

    localparam logic [1:0] MODE_NTT  = 2'b00;
    localparam logic [1:0] MODE_INTT = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [6:0] tw;
    } bf_addr_t;

    // Butterfly operand pair and twiddle index for butterfly j of a layer.
    // Forward layers shrink the span (128 -> 2); inverse layers grow it (2 -> 128).
    // Any mode other than INTT walks the forward schedule.
    function automatic bf_addr_t calc_bf_addr(
        input logic [1:0] mode,
        input logic [2:0] layer,
        input logic [6:0] j
    );
        bf_addr_t   r;
        logic [7:0] len;
        logic [6:0] g;
        logic [7:0] g8;
        logic [7:0] o8;
        if (mode == MODE_INTT) begin
            len  = 8'd2 << layer;
            g    = j >> (layer + 3'd1);
            r.tw = (7'd127 >> layer) - g;
        end else begin
            len  = 8'd128 >> layer;
            g    = j >> (3'd7 - layer);
            r.tw = (7'd1 << layer) + g;
        end
        g8  = {1'b0, g};
        o8  = {1'b0, j} & (len - 8'd1);
        r.a = ((len * g8) << 1) + o8;
        r.b = r.a + len;
        return r;
    endfunction

endpackage

// File: rtl/ntt_delay_line.sv
// rtl/ntt_delay_line.sv - fixed-depth shift register carrying read-side info to the write-back side
module ntt_delay_line #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    // Each stage takes the previous stage's value; stage 0 takes the input.
    always_comb begin
        stage_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Shift every cycle; reset flushes all in-flight entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/ntt_addr_gen.sv
// rtl/ntt_addr_gen.sv - layer/butterfly sequencer producing RAM read, twiddle and write-back addresses
module ntt_addr_gen
    import ntt_pkg::*;
#(
    parameter int PIPE_LAT = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] mode_in,
    input  logic       hold,
    output logic       rd_valid,
    output logic [7:0] rd_addr_a,
    output logic [7:0] rd_addr_b,
    output logic [6:0] tw_addr,
    output logic [1:0] bf_mode,
    output logic       wr_en,
    output logic [7:0] wr_addr_a,
    output logic [7:0] wr_addr_b,
    output logic       busy,
    output logic       done
);

    localparam logic [3:0] DRAIN_LEN  = 4'(PIPE_LAT);
    localparam logic [2:0] LAST_LAYER = 3'(LAYERS - 1);
    localparam logic [6:0] LAST_J     = 7'(N / 2 - 1);
    localparam int         DL_W       = 17;

    state_e     state_q,    state_d;
    logic [2:0] layer_q,    layer_d;
    logic [6:0] j_q,        j_d;
    logic [3:0] drain_q,    drain_d;
    logic [1:0] mode_q,     mode_d;
    logic       rd_valid_q, rd_valid_d;
    logic [7:0] rd_a_q,     rd_a_d;
    logic [7:0] rd_b_q,     rd_b_d;
    logic [6:0] tw_q,       tw_d;
    logic       done_q,     done_d;

    bf_addr_t         cur;
    logic [DL_W-1:0]  dl_in;
    logic [DL_W-1:0]  dl_out;

    // Next-state, counters and the next values of the registered read-side outputs.
    always_comb begin
        state_d    = state_q;
        layer_d    = layer_q;
        j_d        = j_q;
        drain_d    = drain_q;
        mode_d     = mode_q;
        rd_valid_d = 1'b0;
        rd_a_d     = 8'd0;
        rd_b_d     = 8'd0;
        tw_d       = 7'd0;
        done_d     = 1'b0;
        cur        = calc_bf_addr(mode_q, layer_q, j_q);

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ISSUE;
                    layer_d = 3'd0;
                    j_d     = 7'd0;
                    mode_d  = mode_in;
                end
            end
            ST_ISSUE: begin
                if (!hold) begin
                    rd_valid_d = 1'b1;
                    rd_a_d     = cur.a;
                    rd_b_d     = cur.b;
                    tw_d       = cur.tw;
                    if (j_q == LAST_J) begin
                        state_d = ST_DRAIN;
                        drain_d = DRAIN_LEN;
                        j_d     = 7'd0;
                    end else begin
                        j_d = j_q + 7'd1;
                    end
                end
            end
            ST_DRAIN: begin
                // Let the last butterflies of the layer write back before the
                // next layer reads them.
                if (drain_q == 4'd1) begin
                    drain_d = 4'd0;
                    if (layer_q == LAST_LAYER) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ISSUE;
                        layer_d = layer_q + 3'd1;
                        j_d     = 7'd0;
                    end
                end else begin
                    drain_d = drain_q - 4'd1;
                end
            end
            ST_DONE: begin
                // done lands the cycle after the final write-back strobe.
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            layer_q    <= 3'd0;
            j_q        <= 7'd0;
            drain_q    <= 4'd0;
            mode_q     <= 2'b00;
            rd_valid_q <= 1'b0;
            rd_a_q     <= 8'd0;
            rd_b_q     <= 8'd0;
            tw_q       <= 7'd0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            layer_q    <= layer_d;
            j_q        <= j_d;
            drain_q    <= drain_d;
            mode_q     <= mode_d;
            rd_valid_q <= rd_valid_d;
            rd_a_q     <= rd_a_d;
            rd_b_q     <= rd_b_d;
            tw_q       <= tw_d;
            done_q     <= done_d;
        end
    end

    assign dl_in = {rd_valid_q, rd_a_q, rd_b_q};

    ntt_delay_line #(
        .WIDTH (DL_W),
        .DEPTH (PIPE_LAT)
    ) u_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (dl_in),
        .dout  (dl_out)
    );

    assign rd_valid  = rd_valid_q;
    assign rd_addr_a = rd_a_q;
    assign rd_addr_b = rd_b_q;
    assign tw_addr   = tw_q;
    assign bf_mode   = mode_q;
    assign wr_en     = dl_out[16];
    assign wr_addr_a = dl_out[15:8];
    assign wr_addr_b = dl_out[7:0];
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_ntt_addr_gen.sv
// tb/tb_ntt_addr_gen.sv - directed, table-driven self-checking bench for ntt_addr_gen
module tb_ntt_addr_gen;

    localparam int PL        = 3;
    localparam int LAYER_CYC = 128 + PL;
    localparam int TOTAL     = 896;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       hold = 1'b0;
    logic [1:0] mode_in = 2'b00;
    logic       rd_valid;
    logic [7:0] rd_addr_a;
    logic [7:0] rd_addr_b;
    logic [6:0] tw_addr;
    logic [1:0] bf_mode;
    logic       wr_en;
    logic [7:0] wr_addr_a;
    logic [7:0] wr_addr_b;
    logic       busy;
    logic       done;

    ntt_addr_gen #(.PIPE_LAT(PL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mode_in   (mode_in),
        .hold      (hold),
        .rd_valid  (rd_valid),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .tw_addr   (tw_addr),
        .bf_mode   (bf_mode),
        .wr_en     (wr_en),
        .wr_addr_a (wr_addr_a),
        .wr_addr_b (wr_addr_b),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic       clr      = 1'b0;
    logic [1:0] exp_mode = 2'b00;
    int n_rd = 0, n_wr = 0, n_done = 0, n_zero_bad = 0, n_mode_bad = 0, done_cyc = 0;
    int rd_a [1024];
    int rd_b [1024];
    int rd_tw [1024];
    int rd_cyc [1024];
    int wr_a [1024];
    int wr_b [1024];
    int wr_cyc [1024];

    always @(negedge clk) begin
        if (clr) begin
            n_rd       <= 0;
            n_wr       <= 0;
            n_done     <= 0;
            n_zero_bad <= 0;
            n_mode_bad <= 0;
            done_cyc   <= 0;
        end else begin
            if (rd_valid) begin
                if (n_rd < 1024) begin
                    rd_a[n_rd]   <= int'(rd_addr_a);
                    rd_b[n_rd]   <= int'(rd_addr_b);
                    rd_tw[n_rd]  <= int'(tw_addr);
                    rd_cyc[n_rd] <= cyc;
                end
                n_rd <= n_rd + 1;
            end
            if (wr_en) begin
                if (n_wr < 1024) begin
                    wr_a[n_wr]   <= int'(wr_addr_a);
                    wr_b[n_wr]   <= int'(wr_addr_b);
                    wr_cyc[n_wr] <= cyc;
                end
                n_wr <= n_wr + 1;
            end
            n_zero_bad <= n_zero_bad
                + int'(!rd_valid && ({rd_addr_a, rd_addr_b, tw_addr} != 23'd0))
                + int'(!wr_en && ({wr_addr_a, wr_addr_b} != 16'd0));
            if (done) begin
                n_done   <= n_done + 1;
                done_cyc <= cyc;
            end
            if (busy && (bf_mode != exp_mode)) n_mode_bad <= n_mode_bad + 1;
        end
    end

    typedef struct {
        logic [1:0] mode;
        int         idx;
        int         a;
        int         b;
        int         tw;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start(input logic [1:0] m);
        @(posedge clk);
        #1;
        clr      = 1'b1;
        start    = 1'b1;
        mode_in  = m;
        exp_mode = m;
        @(posedge clk);
        #1;
        start = 1'b0;
        clr   = 1'b0;
    endtask

    task automatic wait_rd(input string tag, input int target);
        for (int k = 0; k < 3000 && n_rd < target; k++) tick(1);
        chk({tag, " reached issue count"}, int'(n_rd >= target), 1);
    endtask

    task automatic wait_done(input string tag);
        for (int k = 0; k < 3000 && n_done == 0; k++) tick(1);
        chk({tag, " done seen"}, int'(n_done > 0), 1);
        tick(4);
    endtask

    task automatic check_run(input string tag, input logic [1:0] m, input int extra);
        int ea [TOTAL];
        int eb [TOTAL];
        int etw [TOTAL];
        int idx;
        int len;
        int groups;
        int seq_bad;
        int wr_bad;
        int cov_bad;
        int seen [256];

        chk({tag, " done pulses"}, n_done, 1);
        chk({tag, " read count"}, n_rd, TOTAL);
        chk({tag, " write count"}, n_wr, TOTAL);
        chk({tag, " first-to-done cycles"}, done_cyc - rd_cyc[0], 7 * LAYER_CYC + extra);
        chk({tag, " layer1 start offset"}, rd_cyc[128] - rd_cyc[0], LAYER_CYC);
        chk({tag, " nonzero idle addresses"}, n_zero_bad, 0);
        chk({tag, " bf_mode changes"}, n_mode_bad, 0);

        idx = 0;
        for (int l = 0; l < 7; l++) begin
            len    = (m == 2'b01) ? (2 << l) : (128 >> l);
            groups = 128 / len;
            for (int g = 0; g < groups; g++) begin
                for (int o = 0; o < len; o++) begin
                    ea[idx]  = 2 * len * g + o;
                    eb[idx]  = ea[idx] + len;
                    etw[idx] = (m == 2'b01) ? ((128 >> l) - 1 - g) : ((1 << l) + g);
                    idx++;
                end
            end
        end
        seq_bad = 0;
        wr_bad  = 0;
        for (int i = 0; i < TOTAL; i++) begin
            if (rd_a[i] != ea[i] || rd_b[i] != eb[i] || rd_tw[i] != etw[i]) seq_bad++;
            if (wr_a[i] != rd_a[i] || wr_b[i] != rd_b[i] || wr_cyc[i] != rd_cyc[i] + PL) wr_bad++;
        end
        chk({tag, " sequence mismatches"}, seq_bad, 0);
        chk({tag, " write-back mismatches"}, wr_bad, 0);

        cov_bad = 0;
        for (int l = 0; l < 7; l++) begin
            for (int k = 0; k < 256; k++) seen[k] = 0;
            for (int i = 0; i < 128; i++) begin
                seen[rd_a[l*128+i] & 255]++;
                seen[rd_b[l*128+i] & 255]++;
            end
            for (int k = 0; k < 256; k++) if (seen[k] != 1) cov_bad++;
        end
        chk({tag, " coverage errors"}, cov_bad, 0);

        for (int v = 0; v < 17; v++) begin
            if (vecs[v].mode == m) begin
                chk($sformatf("%s issue %0d a", tag, vecs[v].idx), rd_a[vecs[v].idx], vecs[v].a);
                chk($sformatf("%s issue %0d b", tag, vecs[v].idx), rd_b[vecs[v].idx], vecs[v].b);
                chk($sformatf("%s issue %0d tw", tag, vecs[v].idx), rd_tw[vecs[v].idx], vecs[v].tw);
            end
        end
    endtask

    initial begin
        int gaps;
        int gap_size;
        int snap;

        vecs[0]  = '{2'b00,   0,   0, 128,   1};
        vecs[1]  = '{2'b00, 127, 127, 255,   1};
        vecs[2]  = '{2'b00, 128,   0,  64,   2};
        vecs[3]  = '{2'b00, 191,  63, 127,   2};
        vecs[4]  = '{2'b00, 192, 128, 192,   3};
        vecs[5]  = '{2'b00, 261,   5,  37,   4};
        vecs[6]  = '{2'b00, 771,   5,   7,  65};
        vecs[7]  = '{2'b00, 895, 253, 255, 127};
        vecs[8]  = '{2'b01,   0,   0,   2, 127};
        vecs[9]  = '{2'b01,   1,   1,   3, 127};
        vecs[10] = '{2'b01,   2,   4,   6, 126};
        vecs[11] = '{2'b01, 128,   0,   4,  63};
        vecs[12] = '{2'b01, 129,   1,   5,  63};
        vecs[13] = '{2'b01, 130,   2,   6,  63};
        vecs[14] = '{2'b01, 132,   8,  12,  62};
        vecs[15] = '{2'b01, 768,   0, 128,   1};
        vecs[16] = '{2'b01, 895, 127, 255,   1};

        tick(3);
        chk("reset busy", int'(busy), 0);
        chk("reset rd_valid", int'(rd_valid), 0);
        chk("reset wr_en", int'(wr_en), 0);
        chk("reset done", int'(done), 0);
        chk("reset bf_mode", int'(bf_mode), 0);
        chk("reset addresses", int'(rd_addr_a) + int'(rd_addr_b) + int'(tw_addr)
                               + int'(wr_addr_a) + int'(wr_addr_b), 0);
        rst_n = 1'b1;
        tick(2);

        // Forward transform; a stray start and mode change mid-run must be ignored.
        do_start(2'b00);
        chk("busy after start", int'(busy), 1);
        wait_rd("ntt", 200);
        start   = 1'b1;
        mode_in = 2'b01;
        tick(1);
        start = 1'b0;
        wait_done("ntt");
        chk("ntt busy after done", int'(busy), 0);
        check_run("ntt", 2'b00, 0);

        // Inverse transform.
        do_start(2'b01);
        wait_done("intt");
        check_run("intt", 2'b01, 0);

        // Forward transform with a 5-cycle hold inside layer 2.
        do_start(2'b00);
        wait_rd("hold", 270);
        hold = 1'b1;
        tick(5);
        hold = 1'b0;
        wait_done("hold");
        check_run("hold", 2'b00, 5);
        gaps     = 0;
        gap_size = 0;
        for (int i = 256; i < 383; i++) begin
            if (rd_cyc[i+1] - rd_cyc[i] != 1) begin
                gaps++;
                gap_size = rd_cyc[i+1] - rd_cyc[i] - 1;
            end
        end
        chk("hold gap count", gaps, 1);
        chk("hold gap length", gap_size, 5);

        // Reset in the middle of layer 2, then a clean restart.
        do_start(2'b00);
        wait_rd("abort", 300);
        rst_n = 1'b0;
        #1;
        chk("abort rd_valid", int'(rd_valid), 0);
        chk("abort busy", int'(busy), 0);
        chk("abort addresses", int'(rd_addr_a) + int'(rd_addr_b) + int'(tw_addr), 0);
        chk("abort wr_en", int'(wr_en), 0);
        snap = n_wr;
        tick(3);
        rst_n = 1'b1;
        tick(10);
        chk("abort writes after reset", n_wr - snap, 0);
        chk("abort idle after reset", int'(busy), 0);
        do_start(2'b00);
        wait_done("restart");
        check_run("restart", 2'b00, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
